// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state and bus owner encodings.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  // Wide enough for WAIT_CYCLES in 0..15.
  localparam int unsigned TIMER_W = 4;

endpackage

// File: rtl/mem_bus_arbiter_wait_timer.sv
// mem_wait_timer: loadable down-counter sequencing the memory wait states.
// load_i has priority over en_i; the count stops at zero.
module mem_wait_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload on grant, otherwise decrement while the access runs.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between instruction fetch (IF) and the
// load/store path (D). IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP (one-cycle ready).
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to force an IF grant after
// STARVE_MAX consecutive D grants made while IF was waiting.
module mem_bus_arbiter #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);
  import mem_bus_arbiter_pkg::*;

  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 0..15");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("STARVE_MAX must be at least 1");
  end

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ready_q, if_ready_d;
  logic          d_ready_q, d_ready_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          tmr_load, tmr_en, tmr_zero;
  logic          grant_d;

  mem_wait_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (TIMER_W'(WAIT_CYCLES)),
    .zero_o     (tmr_zero)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  logic [SW-1:0] starve_q, starve_d;

  // D wins unless IF has been passed over STARVE_MAX times in a row.
  always_comb begin
    grant_d  = d_req && !((starve_q >= SW'(STARVE_MAX)) && if_req);
    starve_d = starve_q;
    if ((state_q == ST_IDLE) && (d_req || if_req)) begin
      if (!grant_d)                                    starve_d = '0;
      else if (if_req && (starve_q < SW'(STARVE_MAX))) starve_d = starve_q + 1'b1;
    end
  end

  // Consecutive-D-grant counter.
  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign grant_d = d_req;
`endif

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (d_req || if_req) begin
          owner_d    = grant_d ? OWN_D : OWN_IF;
          mem_addr_d = grant_d ? d_addr : if_addr;
          mem_we_d   = grant_d & d_we;
          if (grant_d) mem_wdata_d = d_wdata;
          mem_en_d   = 1'b1;
          tmr_load   = 1'b1;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          // Stores leave d_rdata untouched; only loads and fetches capture.
          if (owner_q == OWN_IF)  if_rdata_d = mem_rdata;
          else if (!mem_we_q)     d_rdata_d  = mem_rdata;
          if_ready_d = (owner_q == OWN_IF);
          d_ready_d  = (owner_q == OWN_D);
          mem_en_d   = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access without a ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall     = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule
